// File: rtl/cmc_recon_pe.sv
// CMC decoder reconstruction PE: rebuilds a pixel block row by row as clamp(ref + residual).
// Uses a single registered output stage with a row FSM and per-block saturation statistics.
module cmc_recon_pe #(
    parameter  int PIX_W = 16,
    parameter  int LANES = 8,
    parameter  int ROWS  = 8,
    localparam int RW    = $clog2(ROWS) + 1,
    localparam int SW    = $clog2(LANES * ROWS + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_skip,
    input  logic [LANES*PIX_W-1:0]     in_ref,
    input  logic [LANES*(PIX_W+1)-1:0] in_res,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*PIX_W-1:0]     out_pix,
    output logic [RW-1:0]              out_row,
    output logic                       out_last,
    output logic                       block_done,
    output logic [SW-1:0]              sat_count,
    output logic                       busy
);

    localparam int CW = $clog2(LANES + 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [RW-1:0]            row_cnt;
    logic                     skip_q;
    logic [SW-1:0]            run_sat;

    logic                     in_fire;
    logic                     is_last;
    logic                     skip_eff;
    logic [LANES*PIX_W-1:0]   rec_row;
    logic [LANES-1:0]         lane_sat;
    logic [CW-1:0]            row_sat;
    logic [PIX_W+1:0]         sum;

    assign in_ready   = !rst && (!out_valid || out_ready);
    assign in_fire    = in_valid && in_ready;
    assign is_last    = (row_cnt == RW'(ROWS - 1));
    assign skip_eff   = (state == IDLE) ? in_skip : skip_q;
    assign block_done = out_valid && out_ready && out_last;

    // Bit PIX_W+1 of the widened sum flags underflow, bit PIX_W flags overflow.
    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        rec_row  = '0;
        lane_sat = '0;
        sum      = '0;
        for (int k = 0; k < LANES; k++) begin
            sum = {2'b00, in_ref[k*PIX_W +: PIX_W]}
                + {in_res[k*(PIX_W+1) + PIX_W], in_res[k*(PIX_W+1) +: PIX_W+1]};
            if (skip_eff) begin
                rec_row[k*PIX_W +: PIX_W] = in_ref[k*PIX_W +: PIX_W];
            end else if (sum[PIX_W+1]) begin
                rec_row[k*PIX_W +: PIX_W] = '0;
                lane_sat[k]               = 1'b1;
            end else if (sum[PIX_W]) begin
                rec_row[k*PIX_W +: PIX_W] = '1;
                lane_sat[k]               = 1'b1;
            end else begin
                rec_row[k*PIX_W +: PIX_W] = sum[PIX_W-1:0];
            end
        end
    end

    always_comb begin
        row_sat = '0;
        for (int k = 0; k < LANES; k++) begin
            row_sat = row_sat + CW'(lane_sat[k]);
        end
    end

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_fire && !is_last) state_nxt = ACTIVE;
            ACTIVE:  if (in_fire && is_last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ACTIVE);
    end

    // Row counter, latched skip flag and running saturation count of the block being received.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_cnt   <= '0;
            skip_q    <= 1'b0;
            run_sat   <= '0;
            sat_count <= '0;
        end else begin
            if (in_fire) begin
                row_cnt <= is_last ? '0 : row_cnt + 1'b1;
                if (state == IDLE) begin
                    skip_q  <= in_skip;
                    run_sat <= SW'(row_sat);
                end else begin
                    run_sat <= run_sat + SW'(row_sat);
                end
            end
            // run_sat still holds the finishing block here even if the next block's row 0 lands now.
            if (block_done) begin
                sat_count <= run_sat;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_pix   <= '0;
            out_row   <= '0;
            out_last  <= 1'b0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_fire) begin
                out_pix  <= rec_row;
                out_row  <= row_cnt;
                out_last <= is_last;
            end
        end
    end

endmodule

// File: tb/tb_cmc_recon_pe.sv
// Self-checking bench for cmc_recon_pe: a directed driver pushes expected rows to a scoreboard,
// and a monitor pops and compares them as the DUT hands rows downstream.
module tb_cmc_recon_pe;

    localparam int PIX_W = 16;
    localparam int LANES = 8;
    localparam int ROWS  = 8;
    localparam int RW    = $clog2(ROWS) + 1;
    localparam int SW    = $clog2(LANES * ROWS + 1);

    typedef struct {
        logic [LANES*PIX_W-1:0] pix;
        int                     row;
        bit                     last;
    } exp_t;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       in_valid;
    logic                       in_ready;
    logic                       in_skip;
    logic [LANES*PIX_W-1:0]     in_ref;
    logic [LANES*(PIX_W+1)-1:0] in_res;
    logic                       out_valid;
    logic                       out_ready;
    logic [LANES*PIX_W-1:0]     out_pix;
    logic [RW-1:0]              out_row;
    logic                       out_last;
    logic                       block_done;
    logic [SW-1:0]              sat_count;
    logic                       busy;

    exp_t sbq[$];
    int   satq[$];
    int   done_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   n_out = 0;
    int   first_acc_cyc = 0;
    bit   tb_skip = 0;
    int   blk_sat = 0;
    bit   sat_pending = 0;
    int   sat_exp = 0;

    cmc_recon_pe #(.PIX_W(PIX_W), .LANES(LANES), .ROWS(ROWS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_skip   (in_skip),
        .in_ref    (in_ref),
        .in_res    (in_res),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pix   (out_pix),
        .out_row   (out_row),
        .out_last  (out_last),
        .block_done(block_done),
        .sat_count (sat_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model works in plain integers rather than widened bit vectors.
    task automatic model(input logic [LANES*PIX_W-1:0] r, input logic [LANES*(PIX_W+1)-1:0] d,
                         input bit skip, output logic [LANES*PIX_W-1:0] p, output int ns);
        ns = 0;
        p  = '0;
        for (int k = 0; k < LANES; k++) begin
            int rv;
            int dv;
            int s;
            rv = int'(r[k*PIX_W +: PIX_W]);
            dv = int'($signed(d[k*(PIX_W+1) +: PIX_W+1]));
            s  = rv + dv;
            if (skip) s = rv;
            else if (s < 0) begin s = 0; ns++; end
            else if (s > 65535) begin s = 65535; ns++; end
            p[k*PIX_W +: PIX_W] = s[PIX_W-1:0];
        end
    endtask

    // Monitor: compare each accepted output row and the block statistics that follow it.
    always @(negedge clk) begin
        if (!rst) begin
            if (sat_pending) begin
                chk("sat_count", sat_count, sat_exp);
                sat_pending = 0;
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    n_out++;
                    chk("out_pix", out_pix, e.pix);
                    chk("out_row", out_row, e.row);
                    chk("out_last", out_last, e.last);
                    chk("block_done", block_done, e.last);
                end
            end else if (out_valid) begin
                chk("block_done_idle", block_done, 0);
            end
            if (block_done) begin
                done_q.push_back(cyc);
                if (satq.size() == 0) begin
                    chk("unexpected_block_done", 1, 0);
                end else begin
                    sat_exp     = satq.pop_front();
                    sat_pending = 1;
                end
            end
        end
    end

    task automatic send_beat(input logic [LANES*PIX_W-1:0] r, input logic [LANES*(PIX_W+1)-1:0] d,
                             input bit skip, input int row);
        int waited = 0;
        bit done = 0;
        in_valid = 1;
        in_ref   = r;
        in_res   = d;
        in_skip  = skip;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                exp_t e;
                int   ns;
                if (row == 0) begin
                    tb_skip       = skip;
                    blk_sat       = 0;
                    first_acc_cyc = cyc;
                end
                model(r, d, tb_skip, e.pix, ns);
                e.row  = row;
                e.last = (row == ROWS - 1);
                sbq.push_back(e);
                blk_sat += ns;
                if (row == ROWS - 1) satq.push_back(blk_sat);
                done = 1;
            end else if (++waited > 50) begin
                chk("in_ready_wait_bound", waited, 0);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_block(input int kind, input int nrows, input int stall_row, input bit keep_valid);
        for (int row = 0; row < nrows; row++) begin
            logic [LANES*PIX_W-1:0]     r;
            logic [LANES*(PIX_W+1)-1:0] d;
            bit                         s;
            r = '0;
            d = '0;
            s = 0;
            for (int k = 0; k < LANES; k++) begin
                int rv;
                int dv;
                rv = 0;
                dv = 0;
                case (kind)
                    0: begin rv = 1000; dv = 5; end
                    1: begin
                        if (k == 0) begin rv = 65530; dv = 100; end
                        if (k == 1) begin rv = 3;     dv = -10; end
                    end
                    2: begin rv = 50 * k + 7 * row + 1; dv = -500; s = (row == 0); end
                    3: begin
                        rv = int'($urandom_range(65535));
                        dv = int'($urandom_range(131071)) - 65536;
                        s  = (row != 0) && ($urandom_range(1) == 1);
                    end
                    default: begin rv = 2000 + k; dv = -3 * k; s = (row != 0); end
                endcase
                r[k*PIX_W +: PIX_W]         = rv[PIX_W-1:0];
                d[k*(PIX_W+1) +: PIX_W+1]   = dv[PIX_W:0];
            end
            if (row == stall_row) begin
                logic [LANES*PIX_W-1:0] snap_pix;
                logic [RW-1:0]          snap_row;
                in_valid  = 1;
                in_ref    = r;
                in_res    = d;
                in_skip   = s;
                out_ready = 0;
                snap_pix  = out_pix;
                snap_row  = out_row;
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_in_ready", in_ready, 0);
                    chk("stall_out_valid", out_valid, 1);
                    chk("stall_out_pix", out_pix, snap_pix);
                    chk("stall_out_row", out_row, snap_row);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1;
            end
            send_beat(r, d, s, row);
        end
        if (!keep_valid) in_valid = 0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((sbq.size() != 0 || sat_pending) && t < 100) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("drain_bound", t >= 100, 0);
    endtask

    initial begin
        int t6_first;
        int out_base;
        rst       = 1;
        in_valid  = 0;
        in_skip   = 0;
        in_ref    = '0;
        in_res    = '0;
        out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pix", out_pix, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sat_count", sat_count, 0);
        @(negedge clk);
        rst = 0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_busy", busy, 0);
        @(posedge clk);
        #1;

        // Plain residual block: every lane 1000 + 5.
        send_block(0, ROWS, -1, 0);
        wait_drain();

        // Saturating lanes at both ends: two clamps per row.
        send_block(1, ROWS, -1, 0);
        wait_drain();
        chk("sat_block_16", sat_count, 16);

        // Reset in the middle of a block discards it and clears the statistics.
        send_block(0, 3, -1, 1);
        chk("mid_block_busy", busy, 1);
        rst = 1;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_pix", out_pix, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_block_done", block_done, 0);
        chk("mid_rst_sat_count", sat_count, 0);
        in_valid = 0;
        sbq.delete();
        satq.delete();
        sat_pending = 0;
        @(negedge clk);
        rst = 0;
        #1;
        chk("mid_post_in_ready", in_ready, 1);
        chk("mid_post_busy", busy, 0);
        @(posedge clk);
        #1;

        // Skip block: residual -500 ignored, nothing counted.
        send_block(2, ROWS, -1, 0);
        wait_drain();
        chk("skip_sat_count", sat_count, 0);

        // Random rows with a five-cycle downstream stall at row 4.
        send_block(3, ROWS, 4, 0);
        wait_drain();

        // Back-to-back blocks; skip asserted only on later beats of the second.
        done_q.delete();
        out_base = n_out;
        send_block(0, ROWS, -1, 1);
        t6_first = first_acc_cyc;
        send_block(4, ROWS, -1, 0);
        wait_drain();
        chk("b2b_out_beats", n_out - out_base, 16);
        chk("b2b_done_count", done_q.size(), 2);
        if (done_q.size() == 2) begin
            chk("b2b_done_first", done_q[0] - t6_first, 8);
            chk("b2b_done_second", done_q[1] - t6_first, 16);
        end
        chk("b2b_sat_count", sat_count, 0);
        chk("final_queue_empty", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
